// File: rtl/l1_sram_sp_arbiter.sv
// l1_sram_sp_arbiter
// Shares one single-port 64-bit byte-enable SRAM between NUM_REQ L1 clients.
// One access per cycle is granted round-robin; read responses return in order
// after the SRAM read latency, tagged with the requester that won the grant.
// After reset the whole array can optionally be zero-filled before any grant.

module l1_sram_sp_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_DEPTH = 1024,
  parameter int OUT_REGS   = 0,
  parameter int INIT_ZERO  = 1
) (
  input  logic                                Clk_CI,
  input  logic                                Rst_RBI,
  input  logic [NUM_REQ-1:0]                  Req_SI,
  input  logic [NUM_REQ-1:0]                  WrEn_SI,
  input  logic [NUM_REQ-1:0][7:0]             BEn_SI,
  input  logic [NUM_REQ-1:0][63:0]            WrData_DI,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  Addr_DI,
  output logic [NUM_REQ-1:0]                  Gnt_SO,
  output logic [NUM_REQ-1:0]                  RVld_SO,
  output logic [63:0]                         RdData_DO,
  output logic                                InitDone_SO,
  output logic                                Mem_CSel_SO,
  output logic                                Mem_WrEn_SO,
  output logic [7:0]                          Mem_BEn_SO,
  output logic [63:0]                         Mem_WrData_DO,
  output logic [ADDR_WIDTH-1:0]               Mem_Addr_DO,
  input  logic [63:0]                         Mem_RdData_DI
);

  // Read latency of the SRAM macro, and depth of the response tag pipe.
  localparam int LAT   = 1 + OUT_REGS;
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } state_t;

  localparam state_t RST_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_ARB;

  state_t                    state_reg, state_next;
  logic [ADDR_WIDTH-1:0]     init_cnt_reg, init_cnt_next;
  logic [IDX_W-1:0]          ptr_reg, ptr_next;

  logic                      gnt_found;
  logic [IDX_W-1:0]          win_idx;
  int                        cand;
  logic                      rd_push;

  // Response pipe: stage 0 is loaded in the grant cycle, the last stage lines
  // up with the cycle in which the SRAM presents the read data.
  logic [LAT-1:0]            pipe_vld_reg;
  logic [LAT-1:0][IDX_W-1:0] pipe_idx_reg;

  // Round-robin search: first requester at or after the pointer, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr_reg) + k) % NUM_REQ;
      if (!gnt_found && Req_SI[IDX_W'(cand)]) begin
        gnt_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  // Next-state logic and SRAM/grant outputs; everything is forced to zero
  // while reset is asserted so nothing leaks out of a held reset.
  always_comb begin
    state_next    = state_reg;
    init_cnt_next = init_cnt_reg;
    ptr_next      = ptr_reg;
    rd_push       = 1'b0;
    Gnt_SO        = '0;
    InitDone_SO   = 1'b0;
    Mem_CSel_SO   = 1'b0;
    Mem_WrEn_SO   = 1'b0;
    Mem_BEn_SO    = '0;
    Mem_WrData_DO = '0;
    Mem_Addr_DO   = '0;
    if (Rst_RBI) begin
      case (state_reg)
        ST_INIT: begin
          Mem_CSel_SO = 1'b1;
          Mem_WrEn_SO = 1'b1;
          Mem_BEn_SO  = 8'hFF;
          Mem_Addr_DO = init_cnt_reg;
          if (init_cnt_reg == LAST_ADDR) begin
            state_next    = ST_ARB;
            init_cnt_next = '0;
          end else begin
            init_cnt_next = init_cnt_reg + 1'b1;
          end
        end
        ST_ARB: begin
          InitDone_SO = 1'b1;
          if (gnt_found) begin
            Gnt_SO[win_idx] = 1'b1;
            Mem_CSel_SO     = 1'b1;
            Mem_WrEn_SO     = WrEn_SI[win_idx];
            Mem_BEn_SO      = BEn_SI[win_idx];
            Mem_WrData_DO   = WrData_DI[win_idx];
            Mem_Addr_DO     = Addr_DI[win_idx];
            rd_push         = ~WrEn_SI[win_idx];
            ptr_next        = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
          end
        end
        default: state_next = RST_STATE;
      endcase
    end
  end

  // State, fill counter and round-robin pointer registers.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_reg    <= RST_STATE;
      init_cnt_reg <= '0;
      ptr_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      init_cnt_reg <= init_cnt_next;
      ptr_reg      <= ptr_next;
    end
  end

  // Shift the {valid, requester} tag of each granted read toward the output.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      pipe_vld_reg <= '0;
      pipe_idx_reg <= '0;
    end else begin
      pipe_vld_reg[0] <= rd_push;
      pipe_idx_reg[0] <= win_idx;
      for (int s = 1; s < LAT; s++) begin
        pipe_vld_reg[s] <= pipe_vld_reg[s-1];
        pipe_idx_reg[s] <= pipe_idx_reg[s-1];
      end
    end
  end

  // Decode the tag leaving the pipe into a one-hot valid per requester.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rvld
      assign RVld_SO[gi] = pipe_vld_reg[LAT-1] && (pipe_idx_reg[LAT-1] == IDX_W'(gi));
    end
  endgenerate

  // Read data is only driven while a response is valid, so it never shows X.
  assign RdData_DO = pipe_vld_reg[LAT-1] ? Mem_RdData_DI : '0;

  // Out-of-range addresses are a caller error; flag them in simulation.
  addr_in_range_a: assert property (@(posedge Clk_CI) disable iff (!Rst_RBI)
    Mem_CSel_SO |-> (int'(Mem_Addr_DO) < DATA_DEPTH));

  gnt_onehot_a: assert property (@(posedge Clk_CI) disable iff (!Rst_RBI)
    $onehot0(Gnt_SO));

endmodule

// File: tb/tb_l1_sram_sp_arbiter.sv
// Bench for l1_sram_sp_arbiter: three requesters, 16-word array, SRAM with one
// output register (read latency 2). Vectors carry hand-derived grants; read
// data expectations come from a reference memory and a response scoreboard.

module tb_l1_sram_sp_arbiter;

  localparam int NR    = 3;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int OREGS = 1;
  localparam int LAT   = 1 + OREGS;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NR-1:0]          req;
  logic [NR-1:0]          wr;
  logic [NR-1:0][7:0]     ben;
  logic [NR-1:0][63:0]    wdata;
  logic [NR-1:0][AW-1:0]  addr;
  logic [NR-1:0]          gnt;
  logic [NR-1:0]          rvld;
  logic [63:0]            rdata;
  logic                   init_done;
  logic                   mem_csel;
  logic                   mem_wren;
  logic [7:0]             mem_ben;
  logic [63:0]            mem_wdata;
  logic [AW-1:0]          mem_addr;
  logic [63:0]            mem_rdata;

  l1_sram_sp_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_DEPTH(DEPTH), .OUT_REGS(OREGS), .INIT_ZERO(1)
  ) dut (
    .Clk_CI(clk), .Rst_RBI(rst_n),
    .Req_SI(req), .WrEn_SI(wr), .BEn_SI(ben), .WrData_DI(wdata), .Addr_DI(addr),
    .Gnt_SO(gnt), .RVld_SO(rvld), .RdData_DO(rdata), .InitDone_SO(init_done),
    .Mem_CSel_SO(mem_csel), .Mem_WrEn_SO(mem_wren), .Mem_BEn_SO(mem_ben),
    .Mem_WrData_DO(mem_wdata), .Mem_Addr_DO(mem_addr), .Mem_RdData_DI(mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM macro model: registered read plus one output register. Seeded with
  // garbage so a missing zero-fill shows up on the first reads.
  logic [63:0] sram [DEPTH];
  logic [63:0] sram_q = '0;
  logic [63:0] sram_q2 = '0;
  logic        sram_seeded = 1'b0;
  always @(posedge clk) begin
    if (!sram_seeded) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= 64'hDEAD_BEEF_0000_0000 | 64'(i);
      sram_seeded <= 1'b1;
    end else if (mem_csel) begin
      if (mem_wren) begin
        for (int b = 0; b < 8; b++)
          if (mem_ben[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        sram_q <= sram[mem_addr];
      end
    end
    sram_q2 <= sram_q;
  end
  assign mem_rdata = sram_q2;

  typedef struct {
    logic [NR-1:0] req;
    logic [NR-1:0] wr;
    logic [7:0]    ben;
    logic [63:0]   wdata;
    logic [AW-1:0] addr;
    logic [NR-1:0] exp_gnt;
  } vec_t;

  typedef struct {
    int          due;
    int          idx;
    logic [63:0] data;
  } rsp_t;

  logic [63:0] ref_mem [DEPTH];
  rsp_t        sb[$];
  vec_t        vq[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_fail = 0;

  function automatic vec_t mk(input logic [NR-1:0] r, input logic [NR-1:0] w,
                              input logic [7:0] be, input logic [63:0] d,
                              input logic [AW-1:0] a, input logic [NR-1:0] g);
    vec_t v;
    v.req = r; v.wr = w; v.ben = be; v.wdata = d; v.addr = a; v.exp_gnt = g;
    return v;
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Compare the response outputs against the head of the scoreboard.
  task automatic check_rsp();
    rsp_t r;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      r = sb.pop_front();
      chk("rvld", 160'(rvld), 160'(3'b001 << r.idx));
      chk("rdata", 160'(rdata), 160'(r.data));
    end else begin
      chk("rvld_idle", 160'(rvld), 160'(0));
    end
  endtask

  task automatic all_zero_check(input string name);
    chk(name, 160'({gnt, rvld, rdata, init_done, mem_csel, mem_wren, mem_ben, mem_wdata, mem_addr}), 160'(0));
  endtask

  task automatic drive_busy();
    req = '1; wr = '0;
    for (int i = 0; i < NR; i++) begin
      ben[i] = 8'hFF; wdata[i] = 64'h0BAD_0000_0000_0000 | 64'(i); addr[i] = AW'(3);
    end
  endtask

  // Apply one vector for one cycle; called and returns at posedge+1.
  task automatic do_cycle(input vec_t v, input string name);
    int               w;
    logic [AW-1:0]    a;
    logic [63:0]      d;
    logic [159:0]     exp_mem;
    req = v.req; wr = v.wr;
    for (int i = 0; i < NR; i++) begin
      ben[i] = v.ben; wdata[i] = v.wdata ^ 64'(i); addr[i] = v.addr + AW'(i);
    end
    w = -1;
    for (int i = 0; i < NR; i++) if (v.exp_gnt[i]) w = i;
    exp_mem = '0;
    if (w >= 0) begin
      a = v.addr + AW'(w);
      d = v.wdata ^ 64'(w);
      exp_mem = 160'({1'b1, v.wr[w], v.ben, d, a});
      if (v.wr[w]) begin
        for (int b = 0; b < 8; b++) if (v.ben[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
      end else begin
        sb.push_back('{due: cyc + LAT, idx: w, data: ref_mem[a]});
      end
    end
    @(negedge clk);
    chk({name, "/gnt"}, 160'(gnt), 160'(v.exp_gnt));
    chk({name, "/mem"}, 160'({mem_csel, mem_wren, mem_ben, mem_wdata, mem_addr}), exp_mem);
    chk({name, "/initdone"}, 160'(init_done), 160'(1));
    check_rsp();
    @(posedge clk); #1; cyc++;
  endtask

  // Assert reset at posedge+1, check outputs clear at once, hold two cycles.
  task automatic reset_hold(input string name);
    drive_busy();
    rst_n = 1'b0;
    #1;
    all_zero_check(name);
    sb.delete();
    repeat (2) @(posedge clk);
    #1; cyc += 2;
  endtask

  // Release reset and follow the zero-fill; optionally re-reset at a count.
  task automatic do_init(input int abort_at);
    drive_busy();
    rst_n = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      if (k == abort_at) begin
        reset_hold("rst_mid_init");
        return;
      end
      @(negedge clk);
      chk("init_cycle", 160'({mem_csel, mem_wren, mem_ben, mem_wdata, mem_addr, gnt, init_done}),
          160'({1'b1, 1'b1, 8'hFF, 64'h0, AW'(k), 3'b000, 1'b0}));
      check_rsp();
      @(posedge clk); #1; cyc++;
    end
    req = '0;
    @(negedge clk);
    chk("init_done_rise", 160'({init_done, gnt, mem_csel}), 160'({1'b1, 3'b000, 1'b0}));
    check_rsp();
    @(posedge clk); #1; cyc++;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic drain();
    vec_t idle;
    idle = mk(3'b000, 3'b000, 8'h00, 64'h0, '0, 3'b000);
    for (int i = 0; i < 8 && sb.size() > 0; i++) do_cycle(idle, "drain");
    if (sb.size() > 0) begin
      n_vec++; n_fail++;
      $display("FAIL drain: %0d responses never arrived, required 0 pending", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    // Round-robin sequence with hand-derived grants (pointer starts at 0).
    vq.push_back(mk(3'b011, 3'b000, 8'h00, 64'hC0FFEE, 4'd0, 3'b001));
    vq.push_back(mk(3'b011, 3'b000, 8'h00, 64'hC0FFEE, 4'd0, 3'b010));
    vq.push_back(mk(3'b011, 3'b000, 8'h00, 64'hC0FFEE, 4'd0, 3'b001));
    vq.push_back(mk(3'b011, 3'b000, 8'h00, 64'hC0FFEE, 4'd0, 3'b010));
    vq.push_back(mk(3'b001, 3'b001, 8'h0F, 64'h1122334455667788, 4'd5, 3'b001));
    vq.push_back(mk(3'b010, 3'b000, 8'h00, 64'h0, 4'd4, 3'b010));
    vq.push_back(mk(3'b010, 3'b000, 8'h00, 64'h0, 4'd0, 3'b010));
    vq.push_back(mk(3'b010, 3'b000, 8'h00, 64'h0, 4'd0, 3'b010));
    vq.push_back(mk(3'b010, 3'b000, 8'h00, 64'h0, 4'd0, 3'b010));
    vq.push_back(mk(3'b010, 3'b000, 8'h00, 64'h0, 4'd0, 3'b010));
    vq.push_back(mk(3'b111, 3'b000, 8'h00, 64'h77, 4'd2, 3'b100));
    vq.push_back(mk(3'b111, 3'b000, 8'h00, 64'h77, 4'd2, 3'b001));
    vq.push_back(mk(3'b111, 3'b000, 8'h00, 64'h77, 4'd2, 3'b010));
    vq.push_back(mk(3'b111, 3'b000, 8'h00, 64'h77, 4'd2, 3'b100));
    vq.push_back(mk(3'b100, 3'b100, 8'h00, 64'hFFFFFFFFFFFFFFFF, 4'd3, 3'b100));
    vq.push_back(mk(3'b001, 3'b000, 8'h00, 64'h0, 4'd5, 3'b001));
    vq.push_back(mk(3'b000, 3'b000, 8'h00, 64'h0, 4'd0, 3'b000));
    vq.push_back(mk(3'b101, 3'b101, 8'hF0, 64'hA5A5A5A5A5A5A5A5, 4'd8, 3'b100));
    vq.push_back(mk(3'b101, 3'b101, 8'hF0, 64'hA5A5A5A5A5A5A5A5, 4'd8, 3'b001));
    vq.push_back(mk(3'b110, 3'b000, 8'h00, 64'h0, 4'd7, 3'b010));
    vq.push_back(mk(3'b110, 3'b000, 8'h00, 64'h0, 4'd7, 3'b100));
    vq.push_back(mk(3'b100, 3'b000, 8'h00, 64'h0, 4'd8, 3'b100));
    vq.push_back(mk(3'b000, 3'b000, 8'h00, 64'h0, 4'd0, 3'b000));

    // Held reset with every requester active: all outputs must be zero.
    drive_busy();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    all_zero_check("rst_zero");

    // Zero-fill after reset, then the vector table.
    do_init(-1);
    for (int i = 0; i < vq.size(); i++) do_cycle(vq[i], $sformatf("v%0d", i));
    drain();

    // Reset in the middle of a read: the response must never appear.
    do_cycle(mk(3'b001, 3'b000, 8'h00, 64'h0, 4'd5, 3'b001), "rd_before_rst");
    reset_hold("rst_mid_read");

    // Reset in the middle of the fill, then a full fill from address 0.
    do_init(7);
    do_init(-1);

    // Refilled array reads back as zero; pointer is back at 0.
    do_cycle(mk(3'b001, 3'b000, 8'h00, 64'h0, 4'd5, 3'b001), "post_rd0");
    do_cycle(mk(3'b010, 3'b000, 8'h00, 64'h0, 4'd7, 3'b010), "post_rd1");
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
